// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: shares one LCD_Controller between two 9-bit {RS,DATA}
// command requesters. It issues the HD44780 init sequence after reset, then
// grants round-robin, with burst locking and a settle delay after every oDone.
// Optional build macro LCD_ARB_WDOG_EN adds a WAIT_DONE watchdog driving oERR.
module lcd_cmd_arbiter #(
    parameter int DLY_CYCLES  = 262142,
    parameter int WDOG_CYCLES = 1048575
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iREQ0_VALID,
    input  logic [8:0] iREQ0_CMD,
    input  logic       iREQ0_LAST,
    output logic       oREQ0_RDY,
    input  logic       iREQ1_VALID,
    input  logic [8:0] iREQ1_CMD,
    input  logic       iREQ1_LAST,
    output logic       oREQ1_RDY,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_START,
    input  logic       iLCD_DONE,
    output logic       oINIT_DONE,
    output logic [1:0] oGRANT,
    output logic       oBUSY,
    output logic       oERR
);

    localparam int DLY_W = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;

    if (DLY_CYCLES < 1 || WDOG_CYCLES < 1) begin : g_param_check
        $error("lcd_cmd_arbiter: DLY_CYCLES and WDOG_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_INIT_ISSUE,
        ST_WAIT_DONE,
        ST_SETTLE,
        ST_ARB
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic               lock_q, lock_d;
    logic               lock_own_q, lock_own_d;
    logic               rr_q, rr_d;          // 1: requester 1 has priority
    logic [7:0]         data_q, data_d;
    logic               rs_q, rs_d;
    logic               start_q, start_d;
    logic               init_done_q, init_done_d;
    logic [1:0]         grant_q, grant_d;
    logic               sel0, sel1;

`ifdef LCD_ARB_WDOG_EN
    localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               err_q, err_d;
`endif

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    init_cmd = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            3'd1:    init_cmd = 8'h0C;  // display on, cursor off
            3'd2:    init_cmd = 8'h01;  // clear
            3'd3:    init_cmd = 8'h06;  // entry mode: increment
            default: init_cmd = 8'h80;  // DDRAM address 0
        endcase
    endfunction

    // A held lock restricts eligibility to its owner; otherwise the requester
    // not served last wins a tie.
    assign sel0 = lock_q ? ~lock_own_q : (iREQ0_VALID & (~iREQ1_VALID | ~rr_q));
    assign sel1 = lock_q ?  lock_own_q : (iREQ1_VALID & (~iREQ0_VALID |  rr_q));

    assign oREQ0_RDY  = (state_q == ST_ARB) & sel0 & iREQ0_VALID;
    assign oREQ1_RDY  = (state_q == ST_ARB) & sel1 & iREQ1_VALID;
    assign oLCD_DATA  = data_q;
    assign oLCD_RS    = rs_q;
    assign oLCD_START = start_q;
    assign oINIT_DONE = init_done_q;
    assign oBUSY      = (state_q != ST_ARB);
    assign oGRANT     = (state_q == ST_ARB && !lock_q) ? 2'b00 : grant_q;
`ifdef LCD_ARB_WDOG_EN
    assign oERR       = err_q;
`else
    assign oERR       = 1'b0;
`endif

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= ST_INIT_ISSUE;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            lock_q      <= 1'b0;
            lock_own_q  <= 1'b0;
            rr_q        <= 1'b0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            start_q     <= 1'b0;
            init_done_q <= 1'b0;
            grant_q     <= 2'b00;
`ifdef LCD_ARB_WDOG_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
            lock_own_q  <= lock_own_d;
            rr_q        <= rr_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            start_q     <= start_d;
            init_done_q <= init_done_d;
            grant_q     <= grant_d;
`ifdef LCD_ARB_WDOG_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    // Next-state logic: init sequencing, done handshake, settle delay, arbitration.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        lock_d      = lock_q;
        lock_own_d  = lock_own_q;
        rr_d        = rr_q;
        data_d      = data_q;
        rs_d        = rs_q;
        start_d     = start_q;
        init_done_d = init_done_q;
        grant_d     = grant_q;
`ifdef LCD_ARB_WDOG_EN
        wd_d        = '0;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_INIT_ISSUE: begin
                data_d  = init_cmd(idx_q);
                rs_d    = 1'b0;
                start_d = 1'b1;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (iLCD_DONE) begin
                    start_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
`ifdef LCD_ARB_WDOG_EN
                else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
                    // Treat a hung controller as done so the bus keeps moving.
                    start_d = 1'b0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_SETTLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_SETTLE: begin
                if (cnt_q == DLY_W'(DLY_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (idx_q < 3'd4) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_INIT_ISSUE;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = ST_ARB;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ARB: begin
                if (oREQ0_RDY) begin
                    data_d     = iREQ0_CMD[7:0];
                    rs_d       = iREQ0_CMD[8];
                    start_d    = 1'b1;
                    grant_d    = 2'b01;
                    rr_d       = 1'b1;
                    lock_d     = ~iREQ0_LAST;
                    lock_own_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                end else if (oREQ1_RDY) begin
                    data_d     = iREQ1_CMD[7:0];
                    rs_d       = iREQ1_CMD[8];
                    start_d    = 1'b1;
                    grant_d    = 2'b10;
                    rr_d       = 1'b0;
                    lock_d     = ~iREQ1_LAST;
                    lock_own_d = 1'b1;
                    state_d    = ST_WAIT_DONE;
                end
            end
            default: state_d = ST_INIT_ISSUE;
        endcase
    end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Self-checking bench for lcd_cmd_arbiter: randomized and directed command
// queues for both requesters, checked against a queue-level ordering model.
module tb_lcd_cmd_arbiter;
    localparam int DLY  = 4;
    localparam int WDOG = 10;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iREQ0_VALID = 1'b0, iREQ0_LAST = 1'b0;
    logic [8:0] iREQ0_CMD = 9'h0;
    logic       iREQ1_VALID = 1'b0, iREQ1_LAST = 1'b0;
    logic [8:0] iREQ1_CMD = 9'h0;
    logic       iLCD_DONE = 1'b0;
    logic       oREQ0_RDY, oREQ1_RDY, oLCD_RS, oLCD_START, oINIT_DONE, oBUSY, oERR;
    logic [7:0] oLCD_DATA;
    logic [1:0] oGRANT;

    lcd_cmd_arbiter #(.DLY_CYCLES(DLY), .WDOG_CYCLES(WDOG)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iREQ0_VALID(iREQ0_VALID), .iREQ0_CMD(iREQ0_CMD), .iREQ0_LAST(iREQ0_LAST), .oREQ0_RDY(oREQ0_RDY),
        .iREQ1_VALID(iREQ1_VALID), .iREQ1_CMD(iREQ1_CMD), .iREQ1_LAST(iREQ1_LAST), .oREQ1_RDY(oREQ1_RDY),
        .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS), .oLCD_START(oLCD_START), .iLCD_DONE(iLCD_DONE),
        .oINIT_DONE(oINIT_DONE), .oGRANT(oGRANT), .oBUSY(oBUSY), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // LCD controller model: done pulses on the third negedge of a start.
    int lcd_age  = 0;
    bit lcd_hang = 1'b0;
    always @(negedge iCLK) begin
        if (!oLCD_START) lcd_age = 0;
        else lcd_age = lcd_age + 1;
        iLCD_DONE = oLCD_START && (lcd_age == 3) && !lcd_hang;
    end

    // Command monitor: records each start with its low-gap length.
    typedef struct { logic [8:0] cmd; logic [1:0] gnt; int gap; } ev_t;
    ev_t        evq[$];
    ev_t        mon_ev;
    logic       start_prev = 1'b0;
    logic [8:0] held = 9'h0;
    int         low_cnt = 0, unstable = 0, early_rdy = 0, idle_early = 0;
    always @(posedge iCLK) begin
        #2;
        if (oLCD_START && !start_prev) begin
            mon_ev.cmd = {oLCD_RS, oLCD_DATA};
            mon_ev.gnt = oGRANT;
            mon_ev.gap = low_cnt;
            evq.push_back(mon_ev);
            held    = {oLCD_RS, oLCD_DATA};
            low_cnt = 0;
        end else if (oLCD_START) begin
            if ({oLCD_RS, oLCD_DATA} !== held) unstable++;
        end else begin
            low_cnt++;
        end
        start_prev = oLCD_START;
        if ((oREQ0_RDY || oREQ1_RDY) && !oINIT_DONE) early_rdy++;
        if (!oBUSY && !oINIT_DONE) idle_early++;
    end

    logic [7:0] init_tbl [5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    logic [9:0] q0[$], q1[$];   // {LAST, RS, DATA}
    int         tb_last = 1;     // requester served last (1 => req0 favoured)

    task automatic wait_init();
        int cyc = 0;
        while (cyc < 300) begin
            @(negedge iCLK);
            cyc++;
            if (oINIT_DONE) break;
            iREQ0_VALID = 1'b1; iREQ0_CMD = 9'($urandom); iREQ0_LAST = 1'($urandom);
            iREQ1_VALID = 1'b1; iREQ1_CMD = 9'($urandom); iREQ1_LAST = 1'($urandom);
        end
        iREQ0_VALID = 1'b0;
        iREQ1_VALID = 1'b0;
        chk("init_done", oINIT_DONE, 1);
        chk("init_count", evq.size(), 5);
        for (int i = 0; i < 5 && i < evq.size(); i++) begin
            chk("init_cmd", evq[i].cmd, {1'b0, init_tbl[i]});
            chk("init_gnt", evq[i].gnt, 0);
            if (i > 0) chk("init_gap", evq[i].gap, DLY + 1);
        end
        #1;
        chk("idle_busy", oBUSY, 0);
        chk("idle_grant", oGRANT, 0);
        chk("rdy_before_init", early_rdy, 0);
        chk("busy_before_init", idle_early, 0);
    endtask

    task automatic release_and_init();
        evq.delete();
        iRST    = 1'b0;
        tb_last = 1;
        wait_init();
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        iREQ0_VALID = 1'b1; iREQ1_VALID = 1'b1;
        repeat (3) @(negedge iCLK);
        #1;
        chk("rst_start", oLCD_START, 0);
        chk("rst_busy", oBUSY, 1);
        chk("rst_init_done", oINIT_DONE, 0);
        chk("rst_grant", oGRANT, 0);
        chk("rst_data", {oLCD_RS, oLCD_DATA}, 0);
        chk("rst_rdy", {oREQ0_RDY, oREQ1_RDY}, 0);
        chk("rst_err", oERR, 0);
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
        @(negedge iCLK);
        release_and_init();
    endtask

    task automatic drive_heads();
        iREQ0_VALID = (q0.size() != 0);
        iREQ0_CMD   = (q0.size() != 0) ? q0[0][8:0] : 9'($urandom);
        iREQ0_LAST  = (q0.size() != 0) ? q0[0][9] : 1'($urandom);
        iREQ1_VALID = (q1.size() != 0);
        iREQ1_CMD   = (q1.size() != 0) ? q1[0][8:0] : 9'($urandom);
        iREQ1_LAST  = (q1.size() != 0) ? q1[0][9] : 1'($urandom);
    endtask

    // Both requesters stay valid while they have queued commands.
    task automatic run_queues();
        logic [9:0] c0[$], c1[$], exp_item[$];
        int         exp_who[$];
        logic [9:0] it;
        int last, lk, n, k, cyc, total, lock_own, who;
        c0 = q0; c1 = q1; last = tb_last; lk = -1;
        while (c0.size() != 0 || c1.size() != 0) begin
            if (lk >= 0) n = lk;
            else if (c0.size() != 0 && c1.size() != 0) n = 1 - last;
            else n = (c0.size() != 0) ? 0 : 1;
            it = (n == 1) ? c1.pop_front() : c0.pop_front();
            exp_who.push_back(n);
            exp_item.push_back(it);
            last = n;
            lk   = it[9] ? -1 : n;
        end
        total = exp_who.size();
        k = 0; cyc = 0; lock_own = -1;
        evq.delete();
        while (k < total && cyc < total * 20 + 60) begin
            @(negedge iCLK);
            cyc++;
            drive_heads();
            #1;
            if (!oBUSY) chk("arb_grant", oGRANT, (lock_own < 0) ? 0 : ((lock_own == 0) ? 1 : 2));
            if (oREQ0_RDY || oREQ1_RDY) begin
                who = oREQ1_RDY ? 1 : 0;
                chk("rdy_both", oREQ0_RDY & oREQ1_RDY, 0);
                chk("winner", who, exp_who[k]);
                it = (who == 1) ? q1.pop_front() : q0.pop_front();
                chk("item", it, exp_item[k]);
                tb_last  = who;
                lock_own = it[9] ? -1 : who;
                @(negedge iCLK);
                cyc++;
                drive_heads();
                #1;
                chk("start", oLCD_START, 1);
                chk("lcd_cmd", {oLCD_RS, oLCD_DATA}, it[8:0]);
                chk("grant", oGRANT, (who == 1) ? 2 : 1);
                chk("rdy_after", oREQ0_RDY | oREQ1_RDY, 0);
                chk("err_low", oERR, 0);
                k++;
            end
        end
        chk("served", k, total);
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
        cyc = 0;
        while (oBUSY && cyc < 60) begin @(negedge iCLK); cyc++; #1; end
        chk("end_busy", oBUSY, 0);
        chk("end_grant", oGRANT, 0);
        chk("ev_count", evq.size(), total);
        for (int i = 1; i < evq.size(); i++) chk("gap", evq[i].gap, DLY + 1);
        chk("data_stable", unstable, 0);
    endtask

    task automatic gen_rand();
        int n0, n1;
        q0.delete(); q1.delete();
        n0 = $urandom_range(0, 4);
        n1 = $urandom_range(0, 4);
        if (n0 + n1 == 0) n0 = 1;
        for (int i = 0; i < n0; i++)
            q0.push_back({(i == n0 - 1) ? 1'b1 : ($urandom_range(0, 9) < 6), 9'($urandom)});
        for (int i = 0; i < n1; i++)
            q1.push_back({(i == n1 - 1) ? 1'b1 : ($urandom_range(0, 9) < 6), 9'($urandom)});
    endtask

    task automatic reset_mid_op();
        int cyc = 0;
        @(negedge iCLK);
        iREQ0_VALID = 1'b1; iREQ0_CMD = 9'h1C3; iREQ0_LAST = 1'b1;
        while (!oLCD_START && cyc < 40) begin @(negedge iCLK); cyc++; end
        iREQ0_VALID = 1'b0;
        chk("mid_start", oLCD_START, 1);
        #2 iRST = 1'b1;
        #1;
        chk("async_start", oLCD_START, 0);
        chk("async_busy", oBUSY, 1);
        chk("async_init", oINIT_DONE, 0);
        repeat (2) @(negedge iCLK);
        release_and_init();
    endtask

`ifdef LCD_ARB_WDOG_EN
    task automatic wdog_test();
        int hi = 0, errs = 0, err_at = -1, cyc = 0;
        lcd_hang = 1'b1;
        @(negedge iCLK);
        iREQ0_VALID = 1'b1; iREQ0_CMD = 9'h145; iREQ0_LAST = 1'b1;
        while (!oLCD_START && cyc < 40) begin @(negedge iCLK); cyc++; end
        iREQ0_VALID = 1'b0;
        chk("wd_start", oLCD_START, 1);
        for (int i = 0; i < 30; i++) begin
            #1;
            if (oLCD_START) hi++;
            if (oERR) begin
                errs++;
                if (err_at < 0) err_at = i;
            end
            @(negedge iCLK);
        end
        chk("wd_start_len", hi, WDOG);
        chk("wd_err_pulses", errs, 1);
        chk("wd_err_time", err_at, WDOG);
        chk("wd_init_kept", oINIT_DONE, 1);
        lcd_hang = 1'b0;
        tb_last  = 0;
        q0.delete(); q1.delete();
        q0.push_back(10'h3A5);
        run_queues();
    endtask
`endif

    initial begin
        do_reset();
        // contention: alternate service, req0 first
        q0 = '{10'h331, 10'h331, 10'h331};
        q1 = '{10'h332, 10'h332, 10'h332};
        run_queues();
        // single request
        q0 = '{10'h352};
        q1.delete();
        run_queues();
        // burst lock on req1 while req0 waits
        q0 = '{10'h3F0, 10'h3F1};
        q1 = '{10'h0A1, 10'h0A2, 10'h2A3};
        run_queues();
        for (int r = 0; r < 10; r++) begin
            gen_rand();
            run_queues();
        end
        reset_mid_op();
        gen_rand();
        run_queues();
`ifdef LCD_ARB_WDOG_EN
        wdog_test();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, limit 400000");
        $fatal(1, "timeout");
    end

endmodule
